tt_um_jimktrains_vslc_timer_bank: RTL and testbench
===================================================

Name: tt_um_jimktrains_vslc_timer_bank

Overview:
Bank of PLC-style timers sitting downstream of the VSLC core's timer clock divider and alongside the executor.
- Consumes the divided timer clock as a level signal, edge-detects it into a tick, and advances per-timer elapsed counters.
- The executor configures each timer (mode, preset), drives its IN bits, and reads back Q bits and elapsed values.
- Q of timer 0 drives the TIMER_OUTPUT pin.

Parameters:
NUM_TIMERS, 4, number of independent timers (index width = clog2(NUM_TIMERS), minimum 1)
CNT_W, 8, width of preset and elapsed counters

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
timer_clk  input  1  divided timer clock (level); each rising edge = one tick
en  input  NUM_TIMERS  per-timer IN signal from executor
cfg_we  input  1  configuration write strobe, one clk per write
cfg_idx  input  clog2(NUM_TIMERS)  timer selected for write
cfg_mode  input  2  0=TON, 1=TOF, 2=TP, 3=disabled
cfg_preset  input  CNT_W  preset in ticks
rd_idx  input  clog2(NUM_TIMERS)  timer selected for readback
rd_elapsed  output  CNT_W  elapsed count of timer rd_idx (combinational mux of registers)
q  output  NUM_TIMERS  registered timer outputs
q_rise  output  NUM_TIMERS  one-clk pulse when q[i] goes 0->1
timer_out  output  1  equals q[0]

Behaviour:
- Reset (async, rst=1): all mode=3, preset=0, elapsed=0, q=0, q_rise=0, en_prev=0; tick_prev=1 so a high timer_clk at release is not a tick.
- Tick detection: tick = timer_clk & ~tick_prev; tick_prev <= timer_clk every clk.
- Counter update rule, all modes: elapsed_next = elapsed+1 only when tick and elapsed != preset. Elapsed saturates at preset, never wraps.
- Config write (cfg_we=1): timer cfg_idx loads mode/preset, clears elapsed and q, and sets en_prev <= en[cfg_idx].
  - Write overrides any tick or en activity on that timer that cycle.
  - Other timers are unaffected.
- TON (mode 0):
  - en=0: elapsed<=0, q<=0.
  - en=1: count per rule; q <= (elapsed_next == preset).
  - preset=0: q rises 1 clk after en rises.
- TOF (mode 1):
  - en=1: elapsed<=0, q<=1.
  - en=0 and q=1: count per rule; q <= (elapsed_next != preset).
  - en=0 and q=0: hold, so no pulse after reset or config.
  - preset=0: q falls 1 clk after en falls.
- TP (mode 2):
  - Rising en (en & ~en_prev) while q=0: q<=1, elapsed<=0.
  - While q=1: count per rule; q <= (elapsed_next != preset).
  - Retrigger while q=1 is ignored; en falling does not truncate the pulse.
  - preset=0: q high for exactly 1 clk.
- Mode 3: elapsed<=0, q<=0, no counting.
- en_prev[i] <= en[i] every clk (except the config case above).
- q_rise[i] <= next_q[i] & ~q[i].
- Latency: q reflects a counting event 1 clk after the tick edge; q_rise is registered alongside q.
- rd_elapsed updates combinationally with rd_idx. Out-of-range rd_idx (non-power-of-2 NUM_TIMERS) returns 0.
- Timers are fully independent; simultaneous ticks on all timers are handled in the same clk.

Test Plan:
- TON: cfg timer0 mode0 preset3; en[0]=1; 3 timer_clk rising edges -> q[0]=1 one clk after third edge, q_rise[0] one-clk pulse, timer_out=1, rd_elapsed(rd_idx=0)=3. Further ticks: elapsed stays 3. en[0]=0 -> q[0]=0, elapsed=0 next clk.
- TOF: cfg timer1 mode1 preset2; en[1] 1->0 -> q[1] stays 1 through first tick, falls 1 clk after second tick. After reset with en=0, q[1] never asserts.
- TP: cfg timer2 mode2 preset4; pulse en[2] for 1 clk, retrigger after 2 ticks -> q[2] high until 1 clk after 4th tick, no extension. preset0 -> q[2] high exactly 1 clk.
- Config collision: timer0 TON at elapsed=2, cfg_we to timer0 with preset5 in the same clk as a tick -> elapsed=0, q=0; timer3 running concurrently is unaffected.
- Reset: assert rst mid-count with timer_clk held high -> q=0, elapsed=0 immediately (async). Deassert -> no spurious tick counted.
- Mode3 and tick edge: timer in mode 3 with en=1 and 10 ticks -> q=0, elapsed=0. timer_clk held high for many clk -> exactly one tick counted.

Source files
------------

// File: rtl/tt_um_jimktrains_vslc_timer_bank_if.sv
// Executor-side bus of the VSLC timer bank.
// Carries the configuration write port (cfg_we/cfg_idx/cfg_mode/cfg_preset)
// and the elapsed-value readback port (rd_idx in, rd_elapsed out).
//   master : executor, drives config and rd_idx, samples rd_elapsed
//   slave  : timer bank, consumes config and rd_idx, drives rd_elapsed
interface tt_um_jimktrains_vslc_timer_bank_if #(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_preset;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_elapsed;

  modport master (
    output cfg_we, cfg_idx, cfg_mode, cfg_preset, rd_idx,
    input  rd_elapsed
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_mode, cfg_preset, rd_idx,
    output rd_elapsed
  );
endinterface

// File: rtl/tt_um_jimktrains_vslc_timer_bank.sv
// Bank of PLC-style timers (TON / TOF / TP / disabled) clocked by ticks
// derived from the divided timer clock.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   timer_clk  : divided timer clock as a level; each rising edge is a tick
//   en         : per-timer IN bits from the executor
//   bus        : config write and elapsed readback (slave modport)
//   q          : registered timer outputs
//   q_rise     : one-clk pulse when q[i] goes 0->1
//   timer_out  : q[0], drives the TIMER_OUTPUT pin
module tt_um_jimktrains_vslc_timer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  timer_clk,
  input  logic [NUM_TIMERS-1:0] en,
  tt_um_jimktrains_vslc_timer_bank_if.slave bus,
  output logic [NUM_TIMERS-1:0] q,
  output logic [NUM_TIMERS-1:0] q_rise,
  output logic                  timer_out
);

  typedef enum logic [1:0] {
    MODE_TON = 2'd0,
    MODE_TOF = 2'd1,
    MODE_TP  = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  mode_e           mode_r    [NUM_TIMERS];
  logic [CNT_W-1:0] preset_r  [NUM_TIMERS];
  logic [CNT_W-1:0] elapsed_r [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] en_prev;
  logic            tick_prev;

  mode_e           mode_n    [NUM_TIMERS];
  logic [CNT_W-1:0] preset_n  [NUM_TIMERS];
  logic [CNT_W-1:0] elapsed_n [NUM_TIMERS];
  logic [CNT_W-1:0] counted   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] q_n;
  logic [NUM_TIMERS-1:0] en_prev_n;
  logic            tick;

  // tick_prev resets high so a timer_clk already high at release is not a tick
  assign tick      = timer_clk & ~tick_prev;
  assign timer_out = q[0];

  // Saturating count shared by all modes: stops at preset, never wraps
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      counted[i] = elapsed_r[i];
      if (tick && (elapsed_r[i] != preset_r[i]))
        counted[i] = elapsed_r[i] + CNT_W'(1);
    end
  end

  // Per-timer next state; a config write to a timer wins over its mode logic
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      mode_n[i]    = mode_r[i];
      preset_n[i]  = preset_r[i];
      elapsed_n[i] = elapsed_r[i];
      q_n[i]       = q[i];
      en_prev_n[i] = en[i];

      if (bus.cfg_we && (int'(bus.cfg_idx) == i)) begin
        mode_n[i]    = mode_e'(bus.cfg_mode);
        preset_n[i]  = bus.cfg_preset;
        elapsed_n[i] = '0;
        q_n[i]       = 1'b0;
      end else begin
        case (mode_r[i])
          MODE_TON: begin
            if (en[i]) begin
              elapsed_n[i] = counted[i];
              q_n[i]       = (counted[i] == preset_r[i]);
            end else begin
              elapsed_n[i] = '0;
              q_n[i]       = 1'b0;
            end
          end
          MODE_TOF: begin
            if (en[i]) begin
              elapsed_n[i] = '0;
              q_n[i]       = 1'b1;
            end else if (q[i]) begin
              elapsed_n[i] = counted[i];
              q_n[i]       = (counted[i] != preset_r[i]);
            end
          end
          MODE_TP: begin
            // Retrigger is ignored while the pulse runs; en falling does not cut it short
            if (!q[i] && en[i] && !en_prev[i]) begin
              elapsed_n[i] = '0;
              q_n[i]       = 1'b1;
            end else if (q[i]) begin
              elapsed_n[i] = counted[i];
              q_n[i]       = (counted[i] != preset_r[i]);
            end
          end
          default: begin
            elapsed_n[i] = '0;
            q_n[i]       = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_prev <= 1'b1;
      en_prev   <= '0;
      q         <= '0;
      q_rise    <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        mode_r[i]    <= MODE_OFF;
        preset_r[i]  <= '0;
        elapsed_r[i] <= '0;
      end
    end else begin
      tick_prev <= timer_clk;
      en_prev   <= en_prev_n;
      q         <= q_n;
      q_rise    <= q_n & ~q;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        mode_r[i]    <= mode_n[i];
        preset_r[i]  <= preset_n[i];
        elapsed_r[i] <= elapsed_n[i];
      end
    end
  end

  // Out-of-range indices (non power-of-2 bank sizes) read back as zero
  always_comb begin
    bus.rd_elapsed = '0;
    if (int'(bus.rd_idx) < NUM_TIMERS)
      bus.rd_elapsed = elapsed_r[bus.rd_idx];
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_timer_bank.sv
// Scoreboard bench for the VSLC timer bank: a driver applies directed and
// random stimulus on the falling edge and queues the reference model's
// expected post-edge outputs; a monitor pops and compares after each
// rising edge.
module tb_tt_um_jimktrains_vslc_timer_bank;
  localparam int NUM_TIMERS = 4;
  localparam int CNT_W      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       timer_clk;
  logic [3:0] en;
  logic [3:0] q;
  logic [3:0] q_rise;
  logic       timer_out;

  tt_um_jimktrains_vslc_timer_bank_if #(.NUM_TIMERS(NUM_TIMERS), .CNT_W(CNT_W)) bus();

  tt_um_jimktrains_vslc_timer_bank #(.NUM_TIMERS(NUM_TIMERS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .timer_clk (timer_clk),
    .en        (en),
    .bus       (bus),
    .q         (q),
    .q_rise    (q_rise),
    .timer_out (timer_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] q_rise;
    logic [7:0] rd_el;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what a PLC timer "knows", in plain integers
  int m_mode    [4];
  int m_preset  [4];
  int m_elapsed [4];
  bit m_q       [4];
  bit m_rise    [4];
  bit m_en_prev [4];
  bit m_tclk_prev;

  logic [1:0] cur_rd;
  logic [3:0] r_en;
  logic       r_tclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s @%0t actual=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int t = 0; t < 4; t++) begin
      m_mode[t] = 3; m_preset[t] = 0; m_elapsed[t] = 0;
      m_q[t] = 0; m_rise[t] = 0; m_en_prev[t] = 0;
    end
    m_tclk_prev = 1'b1;
  endfunction

  function automatic void model_step(input logic [3:0] en_v, input logic tclk_v, input logic we_v,
                                     input logic [1:0] idx_v, input logic [1:0] mode_v,
                                     input logic [7:0] preset_v);
    int tick;
    tick = (tclk_v && !m_tclk_prev) ? 1 : 0;
    m_tclk_prev = tclk_v;
    for (int t = 0; t < 4; t++) begin
      bit was;
      bit now_q;
      int sat;
      was   = m_q[t];
      now_q = was;
      sat   = (m_elapsed[t] + tick > m_preset[t]) ? m_preset[t] : m_elapsed[t] + tick;
      if (we_v && (int'(idx_v) == t)) begin
        m_mode[t]    = int'(mode_v);
        m_preset[t]  = int'(preset_v);
        m_elapsed[t] = 0;
        now_q        = 0;
        m_en_prev[t] = en_v[t];
      end else begin
        case (m_mode[t])
          0: if (en_v[t]) begin
               m_elapsed[t] = sat; now_q = (sat == m_preset[t]);
             end else begin
               m_elapsed[t] = 0; now_q = 0;
             end
          1: if (en_v[t]) begin
               m_elapsed[t] = 0; now_q = 1;
             end else if (was) begin
               m_elapsed[t] = sat; now_q = (sat != m_preset[t]);
             end
          2: if (!was && en_v[t] && !m_en_prev[t]) begin
               m_elapsed[t] = 0; now_q = 1;
             end else if (was) begin
               m_elapsed[t] = sat; now_q = (sat != m_preset[t]);
             end
          default: begin
            m_elapsed[t] = 0; now_q = 0;
          end
        endcase
        m_en_prev[t] = en_v[t];
      end
      m_rise[t] = now_q && !was;
      m_q[t]    = now_q;
    end
  endfunction

  function automatic exp_t model_expect(input logic [1:0] rd);
    exp_t e;
    for (int t = 0; t < 4; t++) begin
      e.q[t]      = m_q[t];
      e.q_rise[t] = m_rise[t];
    end
    e.rd_el = 8'(m_elapsed[rd]);
    return e;
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic [3:0] en_v, input logic tclk_v,
                               input logic we_v, input logic [1:0] idx_v, input logic [1:0] mode_v,
                               input logic [7:0] preset_v, input logic [1:0] rd_v);
    @(negedge clk);
    rst            = rst_v;
    en             = en_v;
    timer_clk      = tclk_v;
    bus.cfg_we     = we_v;
    bus.cfg_idx    = idx_v;
    bus.cfg_mode   = mode_v;
    bus.cfg_preset = preset_v;
    bus.rd_idx     = rd_v;
    if (rst_v) model_reset();
    else model_step(en_v, tclk_v, we_v, idx_v, mode_v, preset_v);
    exp_q.push_back(model_expect(rd_v));
  endtask

  task automatic idle(input logic [3:0] e, input int n);
    repeat (n) applyStimulus(1'b0, e, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
  endtask

  task automatic ticks(input logic [3:0] e, input int n);
    repeat (n) begin
      applyStimulus(1'b0, e, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
      applyStimulus(1'b0, e, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
    end
  endtask

  task automatic configure(input logic [1:0] idx, input logic [1:0] mode, input logic [7:0] preset,
                           input logic [3:0] e);
    applyStimulus(1'b0, e, 1'b0, 1'b1, idx, mode, preset, cur_rd);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for clk
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_q", 32'(q), 32'd0);
    checkOutput("async_reset_elapsed", 32'(bus.rd_elapsed), 32'd0);
    model_reset();
    exp_q.push_back(model_expect(cur_rd));
  endtask

  // Monitor: every rising edge is an output event of this registered design
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("q", 32'(q), 32'(e.q));
        checkOutput("q_rise", 32'(q_rise), 32'(e.q_rise));
        checkOutput("timer_out", 32'(timer_out), 32'(e.q[0]));
        checkOutput("rd_elapsed", 32'(bus.rd_elapsed), 32'(e.rd_el));
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog @%0t actual=running expected=done", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; en = '0; timer_clk = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_mode = '0; bus.cfg_preset = '0; bus.rd_idx = '0;
    cur_rd = 2'd0;
    model_reset();

    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 2'd0);
    #1;
    checkOutput("reset_q", 32'(q), 32'd0);
    checkOutput("reset_q_rise", 32'(q_rise), 32'd0);
    checkOutput("reset_elapsed", 32'(bus.rd_elapsed), 32'd0);
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 2'd0);
    idle(4'b0000, 2);

    $display("[TB] TON timer0 preset 3");
    cur_rd = 2'd0;
    configure(2'd0, 2'd0, 8'd3, 4'b0001);
    ticks(4'b0001, 5);
    idle(4'b0000, 2);

    $display("[TB] TOF timer1 preset 2");
    cur_rd = 2'd1;
    configure(2'd1, 2'd1, 8'd2, 4'b0000);
    idle(4'b0000, 2);
    idle(4'b0010, 2);
    idle(4'b0000, 1);
    ticks(4'b0000, 3);

    $display("[TB] TP timer2 preset 4 with retrigger, then preset 0");
    cur_rd = 2'd2;
    configure(2'd2, 2'd2, 8'd4, 4'b0000);
    idle(4'b0100, 1);
    ticks(4'b0000, 2);
    idle(4'b0100, 1);
    ticks(4'b0000, 4);
    idle(4'b0000, 2);
    configure(2'd2, 2'd2, 8'd0, 4'b0000);
    idle(4'b0100, 1);
    idle(4'b0000, 3);

    $display("[TB] config write colliding with a tick");
    cur_rd = 2'd0;
    configure(2'd3, 2'd0, 8'd9, 4'b0000);
    configure(2'd0, 2'd0, 8'd6, 4'b1001);
    ticks(4'b1001, 2);
    applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 2'd0, 8'd5, cur_rd);
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
    cur_rd = 2'd3;
    ticks(4'b1001, 3);

    $display("[TB] mode 3 timer and held timer_clk");
    configure(2'd3, 2'd3, 8'd0, 4'b1111);
    ticks(4'b1111, 10);
    cur_rd = 2'd1;
    configure(2'd1, 2'd0, 8'd200, 4'b1111);
    repeat (20) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);

    $display("[TB] async reset with timer_clk high");
    cur_rd = 2'd0;
    async_reset();
    repeat (3) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
    configure(2'd0, 2'd0, 8'd2, 4'b1111);
    repeat (4) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, cur_rd);
    ticks(4'b1111, 3);

    $display("[TB] random phase");
    r_en   = 4'b0000;
    r_tclk = 1'b0;
    repeat (1500) begin
      logic       we;
      logic [1:0] idx;
      logic [1:0] mode;
      logic [7:0] preset;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r_en[b] = ~r_en[b];
      r_tclk = 1'($urandom_range(0, 1));
      we     = ($urandom_range(0, 11) == 0);
      idx    = 2'($urandom_range(0, 3));
      mode   = 2'($urandom_range(0, 3));
      preset = 8'($urandom_range(0, 5));
      cur_rd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) async_reset();
      applyStimulus(1'b0, r_en, r_tclk, we, idx, mode, preset, cur_rd);
    end

    idle(4'b0000, 3);
    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
